// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART fetch client
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam logic [23:0] DEFAULT_TIMEOUT = 24'd1_000_000;
  typedef enum logic [2:0] {
    FC_IDLE,
    FC_TX_LOAD,
    FC_TX_WAIT,
    FC_RX_WAIT,
    FC_DONE
  } fc_state_t;
endpackage

// File: rtl/uart_watchdog.sv
// uart_watchdog: clearable enabled counter flagging a terminal count
module uart_watchdog
  import uart_pkg::*;
#(
  parameter int TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = TIMEOUT_W'(DEFAULT_TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TIMEOUT_W-1:0] cnt;
  assign tc = en && cnt == TIMEOUT - TIMEOUT_W'(1);
  // count idle cycles while enabled, parking at the terminal value
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_fetch_client.sv
// uart_fetch_client: byte-serial instruction fetch over a UART request/response exchange
module uart_fetch_client
  import uart_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = TIMEOUT_W'(DEFAULT_TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_busy,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic [7:0]        data_tx,
  output logic              tx_en,
  input  logic              tx_done,
  input  logic              rx_done,
  input  logic [7:0]        rx_byte
);
  localparam int A_BYTES = ADDR_W / BYTE_W;
  localparam int D_BYTES = DATA_W / BYTE_W;
  localparam int CNT_W = $clog2((A_BYTES > D_BYTES ? A_BYTES : D_BYTES) + 1);
  fc_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] asm_word, next_word;
  logic in_wait, wd_clr, wd_tc;
  assign next_word = (asm_word << BYTE_W) | DATA_W'(rx_byte);
  assign in_wait = state == FC_TX_WAIT || state == FC_RX_WAIT;
  assign wd_clr = !in_wait || (state == FC_TX_WAIT && tx_done) || (state == FC_RX_WAIT && rx_done);
  uart_watchdog #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .en(in_wait),
    .tc(wd_tc)
  );
  // fetch sequencer: address bytes out MSB first, response bytes assembled MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FC_IDLE;
      cnt <= '0;
      addr <= '0;
      asm_word <= '0;
      fetch_busy <= 1'b0;
      fetch_data <= '0;
      fetch_valid <= 1'b0;
      fetch_err <= 1'b0;
      data_tx <= '0;
      tx_en <= 1'b1;
    end else begin
      fetch_valid <= 1'b0;
      fetch_err <= 1'b0;
      tx_en <= 1'b1;
      case (state)
        FC_IDLE: if (fetch_req) begin
          addr <= fetch_addr << BYTE_W;
          data_tx <= fetch_addr[ADDR_W-1 -: BYTE_W];
          tx_en <= 1'b0;
          cnt <= '0;
          asm_word <= '0;
          fetch_busy <= 1'b1;
          state <= FC_TX_LOAD;
        end
        FC_TX_LOAD: state <= FC_TX_WAIT;
        FC_TX_WAIT: if (tx_done) begin
          if (cnt == CNT_W'(A_BYTES - 1)) begin
            cnt <= '0;
            state <= FC_RX_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
            data_tx <= addr[ADDR_W-1 -: BYTE_W];
            addr <= addr << BYTE_W;
            tx_en <= 1'b0;
            state <= FC_TX_LOAD;
          end
        end else if (wd_tc) begin
          fetch_err <= 1'b1;
          fetch_busy <= 1'b0;
          state <= FC_IDLE;
        end
        FC_RX_WAIT: if (rx_done) begin
          asm_word <= next_word;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(D_BYTES - 1)) begin
            fetch_data <= next_word;
            fetch_valid <= 1'b1;
            state <= FC_DONE;
          end
        end else if (wd_tc) begin
          fetch_err <= 1'b1;
          fetch_busy <= 1'b0;
          state <= FC_IDLE;
        end
        FC_DONE: begin
          fetch_busy <= 1'b0;
          state <= FC_IDLE;
        end
        default: state <= FC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fetch_client.sv
// tb_uart_fetch_client: directed checks of byte-serial fetch, watchdog and reset behaviour
module tb_uart_fetch_client;
  logic clk = 1'b0, rst = 1'b1;
  logic tx_done = 1'b0, rx_done = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic req8 = 1'b0, req16 = 1'b0;
  logic [7:0] addr8 = 8'h00;
  logic [15:0] addr16 = 16'h0000;
  logic busy8, valid8, err8, tx_en8, busy16, valid16, err16, tx_en16;
  logic [15:0] data8, data16;
  logic [7:0] dtx8, dtx16;
  int tests = 0, fails = 0;
  int lo8 = 0, lo16 = 0, e8 = 0, e16 = 0, v16 = 0;
  always #5 clk = ~clk;
  uart_fetch_client #(.ADDR_W(8), .DATA_W(16), .TIMEOUT_W(24), .TIMEOUT(24'd100)) d8 (
    .clk(clk), .rst(rst), .fetch_req(req8), .fetch_addr(addr8), .fetch_busy(busy8),
    .fetch_data(data8), .fetch_valid(valid8), .fetch_err(err8), .data_tx(dtx8),
    .tx_en(tx_en8), .tx_done(tx_done), .rx_done(rx_done), .rx_byte(rx_byte)
  );
  uart_fetch_client #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_W(24), .TIMEOUT(24'd100)) d16 (
    .clk(clk), .rst(rst), .fetch_req(req16), .fetch_addr(addr16), .fetch_busy(busy16),
    .fetch_data(data16), .fetch_valid(valid16), .fetch_err(err16), .data_tx(dtx16),
    .tx_en(tx_en16), .tx_done(tx_done), .rx_done(rx_done), .rx_byte(rx_byte)
  );
  // tally strobes and pulses mid-cycle
  always @(negedge clk) begin
    if (tx_en8 === 1'b0) lo8++;
    if (tx_en16 === 1'b0) lo16++;
    if (err8 === 1'b1) e8++;
    if (err16 === 1'b1) e16++;
    if (valid16 === 1'b1) v16++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tx_pulse();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask
  task automatic fetch16(input logic [15:0] a);
    addr16 = a;
    req16 = 1'b1;
    step();
    req16 = 1'b0;
    step();
    tx_pulse();
    step();
    tx_pulse();
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(busy8), 32'h0);
    chk("rst_data", 32'(data8), 32'h0);
    chk("rst_valid", 32'(valid8), 32'h0);
    chk("rst_err", 32'(err8), 32'h0);
    chk("rst_dtx", 32'(dtx8), 32'h0);
    chk("rst_tx_en", 32'(tx_en8), 32'h1);
    addr8 = 8'h3C;
    req8 = 1'b1;
    step();
    req8 = 1'b0;
    chk("b_tx_en", 32'(tx_en8), 32'h0);
    chk("b_dtx", 32'(dtx8), 32'h3C);
    chk("b_busy", 32'(busy8), 32'h1);
    repeat (5) step();
    tx_pulse();
    chk("b_one_strobe", 32'(lo8), 32'd1);
    step();
    send(8'hA5);
    step();
    step();
    send(8'h5A);
    chk("b_valid", 32'(valid8), 32'h1);
    chk("b_data", 32'(data8), 32'hA55A);
    chk("b_busy_done", 32'(busy8), 32'h1);
    req8 = 1'b1;
    step();
    chk("b_valid_pulse", 32'(valid8), 32'h0);
    chk("b_idle", 32'(busy8), 32'h0);
    chk("b_no_accept_done", 32'(tx_en8), 32'h1);
    step();
    req8 = 1'b0;
    chk("b_reaccept", 32'(tx_en8), 32'h0);
    chk("b_no_err", 32'(e8), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r8_tx_en", 32'(tx_en8), 32'h1);
    chk("r8_busy", 32'(busy8), 32'h0);
    chk("r8_data", 32'(data8), 32'h0);
    addr16 = 16'h1234;
    req16 = 1'b1;
    step();
    req16 = 1'b0;
    chk("m_tx_en1", 32'(tx_en16), 32'h0);
    chk("m_dtx1", 32'(dtx16), 32'h12);
    step();
    rx_byte = 8'hFF;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    req16 = 1'b1;
    step();
    req16 = 1'b0;
    repeat (3) step();
    chk("m_hold_strobe", 32'(tx_en16), 32'h1);
    chk("m_strobes1", 32'(lo16), 32'd1);
    tx_pulse();
    chk("m_tx_en2", 32'(tx_en16), 32'h0);
    chk("m_dtx2", 32'(dtx16), 32'h34);
    step();
    tx_pulse();
    chk("m_strobes2", 32'(lo16), 32'd2);
    send(8'hC3);
    send(8'h96);
    chk("m_valid", 32'(valid16), 32'h1);
    chk("m_data", 32'(data16), 32'hC396);
    repeat (4) step();
    chk("m_idle", 32'(busy16), 32'h0);
    chk("m_no_queue", 32'(lo16), 32'd2);
    chk("m_one_valid", 32'(v16), 32'd1);
    fetch16(16'h00AB);
    send(8'h77);
    repeat (99) step();
    chk("t_no_err_yet", 32'(err16), 32'h0);
    chk("t_busy_yet", 32'(busy16), 32'h1);
    step();
    chk("t_err", 32'(err16), 32'h1);
    chk("t_busy_drop", 32'(busy16), 32'h0);
    chk("t_data_kept", 32'(data16), 32'hC396);
    step();
    chk("t_err_pulse", 32'(err16), 32'h0);
    chk("t_err_count", 32'(e16), 32'd1);
    fetch16(16'h4242);
    send(8'hBE);
    repeat (99) step();
    send(8'hEF);
    chk("s_valid", 32'(valid16), 32'h1);
    chk("s_err", 32'(err16), 32'h0);
    chk("s_data", 32'(data16), 32'hBEEF);
    step();
    fetch16(16'h0101);
    send(8'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("x_busy", 32'(busy16), 32'h0);
    chk("x_data", 32'(data16), 32'h0);
    chk("x_valid", 32'(valid16), 32'h0);
    chk("x_err", 32'(err16), 32'h0);
    chk("x_dtx", 32'(dtx16), 32'h0);
    chk("x_tx_en", 32'(tx_en16), 32'h1);
    fetch16(16'h5678);
    send(8'h22);
    send(8'h33);
    chk("x_valid_new", 32'(valid16), 32'h1);
    chk("x_data_new", 32'(data16), 32'h2233);
    chk("x_err_total", 32'(e16), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_fetch_client.md
Name: uart_fetch_client

Overview:
- Initiator-side client of the UART block.
- Turns a parallel instruction-fetch request (address in, instruction word out) into a byte-serial request/response exchange.
  - It drives the transmit-side handshake (data_tx, tx_en, tx_done).
  - It consumes the receive-side handshake (rx_done, received byte).
- Sits between the CPU fetch stage and uart_module, so instruction memory can live off-chip behind a host responder.

Parameters:
- ADDR_W, 8, fetch address width; must be a multiple of 8; sent as ADDR_W/8 bytes, MSB byte first.
- DATA_W, 16, fetched word width; must be a multiple of 8; received as DATA_W/8 bytes, MSB byte first.
- TIMEOUT_W, 24, width of the response watchdog counter.
- TIMEOUT, 24'd1_000_000, cycles allowed between consecutive expected events before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  request strobe; sampled only in IDLE
- fetch_addr  in  ADDR_W  address; latched on accepted fetch_req
- fetch_busy  out  1  high from the cycle after acceptance until return to IDLE
- fetch_data  out  DATA_W  last successfully fetched word; holds until the next success
- fetch_valid  out  1  one-cycle pulse, fetch_data is new
- fetch_err  out  1  one-cycle pulse, watchdog abort
- data_tx  out  8  byte to transmit
- tx_en  out  1  active-low one-cycle transmit strobe; idle high
- tx_done  in  1  one-cycle pulse, transmitter finished current byte
- rx_done  in  1  one-cycle pulse, rx_byte valid
- rx_byte  in  8  received byte

Behaviour:
- Reset values:
  - fetch_busy=0, fetch_data=0, fetch_valid=0, fetch_err=0, data_tx=0, tx_en=1.
  - State=IDLE, byte counter=0, watchdog=0.
- State machine:
  - IDLE: fetch_req=1 latches fetch_addr, clears the byte counter, and goes to TX_LOAD. Any rx_done/tx_done is ignored.
  - TX_LOAD (1 cycle):
    - data_tx = address byte[counter], MSB first; tx_en=0 this cycle only.
    - Go to TX_WAIT.
  - TX_WAIT:
    - On tx_done, increment the counter.
    - If more address bytes remain, go to TX_LOAD; else clear the counter and go to RX_WAIT.
  - RX_WAIT:
    - On rx_done, shift rx_byte into the assembly register (MSB first) and increment the counter.
    - After the DATA_W/8-th byte, go to DONE.
  - DONE (1 cycle): fetch_data = assembly register; fetch_valid=1; go to IDLE.
- fetch_busy=1 in every state except IDLE.
- Latency:
  - fetch_req at cycle 0 gives tx_en low at cycle 1.
  - The last rx_done at cycle k gives fetch_valid=1 at cycle k+1, with fetch_data updated in the same cycle.
  - fetch_req may be re-accepted at cycle k+2.
- Watchdog:
  - Cleared on every state transition and every accepted rx_done; increments otherwise in TX_WAIT and RX_WAIT.
  - When it reaches TIMEOUT-1: fetch_err pulses, go to IDLE, fetch_data unchanged, partial bytes discarded.
- Simultaneous events:
  - rx_done in the same cycle as the watchdog terminal count: the byte wins, no error.
  - rx_done during TX_LOAD/TX_WAIT is stale and discarded.
  - fetch_req while busy is ignored; it is not queued.
- Reset mid-operation: the next edge forces IDLE and the reset values; tx_en returns high immediately, even if a byte is in flight.
- Counters are sized to max(ADDR_W, DATA_W)/8 with no wrap.

Decomposition:
- Shared package (uart_pkg):
  - State encoding constants FC_IDLE, FC_TX_LOAD, FC_TX_WAIT, FC_RX_WAIT, FC_DONE.
  - BYTE_W=8.
  - Default TIMEOUT.
- One natural sub-module: uart_watchdog, a clear/enable/terminal-count counter parameterized by TIMEOUT_W and TIMEOUT.
- Byte shift/assembly logic stays inline.

Test Plan:
- Basic fetch:
  - Stimulus: fetch_addr=8'h3C, fetch_req pulse; respond tx_done 5 cycles after tx_en low; rx bytes 8'hA5 then 8'h5A.
  - Required: data_tx=8'h3C with a single tx_en low; fetch_valid one cycle after the second rx_done; fetch_data=16'hA55A; fetch_err never set.
- Multi-byte address (ADDR_W=16):
  - Stimulus: fetch_addr=16'h1234.
  - Required: two tx_en strobes with data_tx 8'h12 then 8'h34; the second strobe comes only after the first tx_done.
- Timeout (TIMEOUT=100):
  - Stimulus: send completes, then one response byte, then silence.
  - Required: fetch_err pulses 100 cycles after that byte; fetch_data keeps its prior value; fetch_busy drops.
- Stale and ignored inputs:
  - Stimulus: rx_done=1 with 8'hFF during TX_WAIT; fetch_req pulsed while busy.
  - Required: the byte is not assembled; exactly one transaction runs.
- Simultaneous byte and terminal count:
  - Stimulus: last rx_done lands on cycle TIMEOUT-1.
  - Required: fetch_valid=1, fetch_err=0.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle in RX_WAIT after one byte.
  - Required: all outputs at reset values next cycle; a new fetch returns the correct word, with no leftover byte from before.
